// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and memory port bundle for dmem_arbiter
// Purpose: groups the two requester ports and the memory port of the arbiter.
// Signals:
//   mX_req/mX_we/mX_lock/mX_addr/mX_wdata  requester -> arbiter
//   mX_gnt/mX_rvalid/mX_rdata              arbiter -> requester
//   mem_we/mem_addr/mem_wdata              arbiter -> memory
//   mem_rdata                              memory -> arbiter (combinational)
// Modports: slave = arbiter side, master = requesters plus memory side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic              m0_lock;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic              m1_lock;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter in front of the single-port data memory
// Purpose: grants at most one access per cycle (m0 = core load/store, m1 = loader/debug),
//   drives the memory port from the winner, and returns read data one cycle later.
//   A requester asserting lock keeps ownership after its access until it transfers
//   with lock low, or drops lock while not requesting.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  synchronous, active-high reset
//   bus  dmem_arbiter_if.slave (requester handshakes, read responses, memory port)
// Configuration: DMEM_ARB_RR_EN defined selects round-robin between contending
//   requesters; undefined selects fixed priority (m0 wins) and drops the last register.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  owner_e            owner_q;
`ifdef DMEM_ARB_RR_EN
  logic              last_q;  // 1 = m1 won most recently, so m0 wins the next contention
`endif
  logic              rvalid0_q;
  logic              rvalid1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic              gnt0;
  logic              gnt1;
  logic              contend_m0;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;

  // Grant: an owner holds the bus even when it is not requesting.
  always_comb begin
`ifdef DMEM_ARB_RR_EN
    contend_m0 = last_q;
`else
    contend_m0 = 1'b1;
`endif
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (owner_q)
        OWN_M0: gnt0 = bus.m0_req;
        OWN_M1: gnt1 = bus.m1_req;
        default: begin
          if (bus.m0_req && bus.m1_req) begin
            gnt0 = contend_m0;
            gnt1 = !contend_m0;
          end else begin
            gnt0 = bus.m0_req;
            gnt1 = bus.m1_req;
          end
        end
      endcase
    end
  end

  // Memory port mirrors the winner, zero when idle.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (gnt0) begin
      mem_we_d    = bus.m0_we;
      mem_addr_d  = bus.m0_addr;
      mem_wdata_d = bus.m0_wdata;
    end else if (gnt1) begin
      mem_we_d    = bus.m1_we;
      mem_addr_d  = bus.m1_addr;
      mem_wdata_d = bus.m1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= OWN_NONE;
`ifdef DMEM_ARB_RR_EN
      last_q    <= 1'b1;
`endif
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= gnt0 && !bus.m0_we;
      rvalid1_q <= gnt1 && !bus.m1_we;
      if (gnt0 && !bus.m0_we) rdata0_q <= bus.mem_rdata;
      if (gnt1 && !bus.m1_we) rdata1_q <= bus.mem_rdata;

      if (gnt0) begin
        owner_q <= bus.m0_lock ? OWN_M0 : OWN_NONE;
      end else if (gnt1) begin
        owner_q <= bus.m1_lock ? OWN_M1 : OWN_NONE;
      end else if (owner_q == OWN_M0 && !bus.m0_req && !bus.m0_lock) begin
        owner_q <= OWN_NONE;
      end else if (owner_q == OWN_M1 && !bus.m1_req && !bus.m1_lock) begin
        owner_q <= OWN_NONE;
      end

`ifdef DMEM_ARB_RR_EN
      if (gnt0) last_q <= 1'b0;
      else if (gnt1) last_q <= 1'b1;
`endif
    end
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rvalid = rvalid0_q;
  assign bus.m1_rvalid = rvalid1_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.mem_we    = mem_we_d;
  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_wdata = mem_wdata_d;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter against a reference model
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory seen by the DUT: combinational read, write on the clock edge.
  logic [31:0] mem_arr [64];
  assign bus.mem_rdata = mem_arr[bus.mem_addr[7:2]];
  always @(posedge clk) if (bus.mem_we === 1'b1) mem_arr[bus.mem_addr[7:2]] <= bus.mem_wdata;

  typedef struct {
    bit          req;
    bit          we;
    bit          lock;
    logic [31:0] addr;
    logic [31:0] wdata;
  } rq_t;

  typedef struct {
    bit          g0;
    bit          g1;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] h0;
    logic [31:0] h1;
  } cyc_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } resp_t;

  cyc_t  cq[$];
  resp_t rq0[$];
  resp_t rq1[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_n  = 0;
  bit started = 1'b0;

  // Reference state: winner ids as integers, owner -1 meaning nobody.
  logic [31:0] ref_mem [64];
  int          m_last  = 1;
  int          m_owner = -1;
  logic [31:0] held [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc_n, act, exp);
    end
  endtask

  function automatic rq_t mk(input bit req, input bit we, input bit lock,
                             input logic [31:0] addr, input logic [31:0] wdata);
    rq_t r;
    r.req = req; r.we = we; r.lock = lock; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  task automatic step(input bit r, input rq_t a, input rq_t b);
    int   win;
    rq_t  w;
    cyc_t e;
    resp_t rs;
    bit   rr;
    @(posedge clk);
    #1;
    rst          = r;
    bus.m0_req   = a.req;  bus.m0_we = a.we;  bus.m0_lock = a.lock;
    bus.m0_addr  = a.addr; bus.m0_wdata = a.wdata;
    bus.m1_req   = b.req;  bus.m1_we = b.we;  bus.m1_lock = b.lock;
    bus.m1_addr  = b.addr; bus.m1_wdata = b.wdata;
    cyc_n++;
`ifdef DMEM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    win = -1;
    if (!r) begin
      if (m_owner == 0) win = a.req ? 0 : -1;
      else if (m_owner == 1) win = b.req ? 1 : -1;
      else if (a.req && b.req) win = rr ? (1 - m_last) : 0;
      else if (a.req) win = 0;
      else if (b.req) win = 1;
    end
    w = (win == 1) ? b : a;
    e.g0    = (win == 0);
    e.g1    = (win == 1);
    e.we    = (win >= 0) ? w.we : 1'b0;
    e.addr  = (win >= 0) ? w.addr : 32'h0;
    e.wdata = (win >= 0) ? w.wdata : 32'h0;
    e.h0    = held[0];
    e.h1    = held[1];
    cq.push_back(e);
    if (r) begin
      m_last = 1; m_owner = -1; held[0] = '0; held[1] = '0;
    end else if (win >= 0) begin
      m_last  = win;
      m_owner = w.lock ? win : -1;
      if (w.we) begin
        ref_mem[w.addr[7:2]] = w.wdata;
      end else begin
        rs.cyc  = cyc_n + 1;
        rs.data = ref_mem[w.addr[7:2]];
        held[win] = rs.data;
        if (win == 0) rq0.push_back(rs); else rq1.push_back(rs);
      end
    end else if (m_owner == 0 && !a.req && !a.lock) begin
      m_owner = -1;
    end else if (m_owner == 1 && !b.req && !b.lock) begin
      m_owner = -1;
    end
  endtask

  // Monitor: per-cycle grant/port/holding checks, read responses popped on rvalid.
  always @(negedge clk) begin
    cyc_t  e;
    resp_t rs;
    if (started) begin
      if (cq.size() > 0) begin
        e = cq.pop_front();
        chk("m0_gnt", {31'b0, bus.m0_gnt}, {31'b0, e.g0});
        chk("m1_gnt", {31'b0, bus.m1_gnt}, {31'b0, e.g1});
        chk("mem_we", {31'b0, bus.mem_we}, {31'b0, e.we});
        chk("mem_addr", bus.mem_addr, e.addr);
        chk("mem_wdata", bus.mem_wdata, e.wdata);
        chk("m0_rdata_hold", bus.m0_rdata, e.h0);
        chk("m1_rdata_hold", bus.m1_rdata, e.h1);
      end
      if (bus.m0_rvalid !== 1'b0) begin
        if (rq0.size() == 0) chk("m0_rvalid_unexpected", {31'b0, bus.m0_rvalid}, 32'h0);
        else begin
          rs = rq0.pop_front();
          chk("m0_rvalid_cycle", cyc_n, rs.cyc);
          chk("m0_rdata", bus.m0_rdata, rs.data);
        end
      end
      if (bus.m1_rvalid !== 1'b0) begin
        if (rq1.size() == 0) chk("m1_rvalid_unexpected", {31'b0, bus.m1_rvalid}, 32'h0);
        else begin
          rs = rq1.pop_front();
          chk("m1_rvalid_cycle", cyc_n, rs.cyc);
          chk("m1_rdata", bus.m1_rdata, rs.data);
        end
      end
    end
  end

  rq_t idle;

  initial begin
    idle = mk(0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = i * 2;
      ref_mem[i] = i * 2;
    end
    held[0] = '0;
    held[1] = '0;
    rst = 1'b1;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_lock = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_lock = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
    @(posedge clk);
    started = 1'b1;

    // Reset state observed, then a single read of word 16.
    step(1, idle, idle);
    step(0, mk(1, 0, 0, 32'h40, 0), idle);
    step(0, idle, idle);

    // Contention for four cycles straight out of reset.
    step(1, idle, idle);
    for (int i = 0; i < 4; i++)
      step(0, mk(1, 0, 0, 32'h44 + 4 * i, 0), mk(1, 0, 0, 32'h60 + 4 * i, 0));

    // m1 locked write pair while m0 keeps requesting.
    step(0, idle, mk(1, 1, 1, 32'h80, 32'h11));
    step(0, mk(1, 0, 0, 32'h04, 0), mk(1, 1, 0, 32'h84, 32'h22));
    step(0, mk(1, 0, 0, 32'h04, 0), idle);
    step(0, mk(1, 0, 0, 32'h08, 0), idle);

    // Idle owner holds the bus until it drops lock.
    step(0, mk(1, 0, 1, 32'h0C, 0), idle);
    step(0, mk(0, 0, 1, 32'h0, 0), mk(1, 0, 0, 32'h30, 0));
    step(0, mk(0, 0, 1, 32'h0, 0), mk(1, 0, 0, 32'h30, 0));
    step(0, idle, mk(1, 0, 0, 32'h30, 0));
    step(0, idle, mk(1, 0, 0, 32'h30, 0));

    // Write then read the same word from the other requester.
    step(0, mk(1, 1, 0, 32'h10, 32'hDEAD), idle);
    step(0, idle, mk(1, 0, 0, 32'h10, 0));
    step(0, idle, idle);

    // Reset collides with a write while m1 has a read response pending and holds lock.
    step(0, idle, mk(1, 0, 1, 32'h14, 0));
    step(1, mk(1, 1, 0, 32'h20, 32'h55), idle);
    step(0, mk(1, 0, 0, 32'h18, 0), idle);
    step(0, idle, idle);

    @(negedge clk);
    #1;
    chk("word32", mem_arr[32], 32'h11);
    chk("word33", mem_arr[33], 32'h22);
    chk("word4", mem_arr[4], 32'hDEAD);
    chk("word8_after_reset_write", mem_arr[8], 32'h10);

    // Randomized traffic with occasional locks and resets.
    for (int i = 0; i < 400; i++) begin
      rq_t a;
      rq_t b;
      a = mk($urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom_range(0, 9) < 3,
             $urandom_range(0, 255), $urandom);
      b = mk($urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom_range(0, 9) < 3,
             $urandom_range(0, 255), $urandom);
      step($urandom_range(0, 49) == 0, a, b);
    end
    step(0, idle, idle);
    step(0, idle, idle);
    @(negedge clk);
    #1;

    for (int i = 0; i < 64; i++) chk("mem_final", mem_arr[i], ref_mem[i]);
    chk("cycle_queue_drained", cq.size(), 0);
    chk("m0_resp_queue_drained", rq0.size(), 0);
    chk("m1_resp_queue_drained", rq1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
